cmd_sequencer: RTL and testbench

Sequences the configuration RAM write port and processing start for the algorithm/byte-position front end. Rising edges on the three command buttons are latched as pending writes. Word 0 receives the algorithm ID (1 or 2) and word 1 receives the start byte position. A round-robin arbiter shares the single RAM write port with a CPU requester. Once both words have been written, the block pulses `start` to the processing core and holds `busy` until `done`.

---
 rtl/cmd_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_cmd_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: turns button edges into config RAM writes (word 0 = algorithm, word 1 = byte
// position), shares the write port round-robin with a CPU, then starts the core. Watchdog: CMD_WDOG_EN.
module cmd_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        btn,
  input  logic [7:0]        bytePos,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              err
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_r;
  logic [2:0]          btn_q_r;
  logic                pend_alg_r, pend_pos_r, alg_done_r, pos_done_r;
  logic [1:0]          alg_val_r;
  logic [DATA_W-1:0]   pos_val_r;
  logic                last_cpu_r;
  logic                mem_we_r, start_r, busy_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;

  logic [2:0]          rise_s;
  logic                int_req_s, cpu_gnt_s, int_gnt_s;
  logic                pend_alg_n_s, pend_pos_n_s, alg_done_n_s, pos_done_n_s;
  logic [1:0]          alg_val_n_s;
  logic                go_run_s;

  // Button edges are only honoured while idle; btn_q still tracks so a press during RUN is consumed.
  assign rise_s    = (state_r == IDLE) ? (btn & ~btn_q_r) : 3'b000;
  assign int_req_s = pend_alg_r | pend_pos_r;

  // Round-robin arbitration between CPU and internal requester; nothing granted during reset.
  always_comb begin
    cpu_gnt_s = 1'b0;
    int_gnt_s = 1'b0;
    if (rst) begin
      cpu_gnt_s = 1'b0;
      int_gnt_s = 1'b0;
    end else if (cpu_req && int_req_s) begin
      if (last_cpu_r) begin
        int_gnt_s = 1'b1;
      end else begin
        cpu_gnt_s = 1'b1;
      end
    end else if (cpu_req) begin
      cpu_gnt_s = 1'b1;
    end else if (int_req_s) begin
      int_gnt_s = 1'b1;
    end else begin
      cpu_gnt_s = 1'b0;
      int_gnt_s = 1'b0;
    end
  end

  // Next pending/done flags: a same-cycle edge re-arms a flag that its grant just cleared.
  always_comb begin
    pend_alg_n_s = pend_alg_r;
    pend_pos_n_s = pend_pos_r;
    alg_val_n_s  = alg_val_r;
    alg_done_n_s = alg_done_r | (int_gnt_s & pend_alg_r);
    pos_done_n_s = pos_done_r | (int_gnt_s & ~pend_alg_r & pend_pos_r);
    if (rise_s[0]) begin
      pend_alg_n_s = 1'b1;
      alg_val_n_s  = 2'd1;
    end else if (rise_s[1]) begin
      pend_alg_n_s = 1'b1;
      alg_val_n_s  = 2'd2;
    end else if (int_gnt_s && pend_alg_r) begin
      pend_alg_n_s = 1'b0;
    end else begin
      pend_alg_n_s = pend_alg_r;
    end
    if (rise_s[2]) begin
      pend_pos_n_s = 1'b1;
    end else if (int_gnt_s && !pend_alg_r && pend_pos_r) begin
      pend_pos_n_s = 1'b0;
    end else begin
      pend_pos_n_s = pend_pos_r;
    end
  end

  assign go_run_s = alg_done_n_s & pos_done_n_s & ~pend_alg_n_s & ~pend_pos_n_s;

`ifdef CMD_WDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wdog_cnt_r;
  logic             err_r;
  assign err = err_r;
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT);
  assign err = 1'b0;
`endif

  // Command latching, write-port register stage and IDLE/RUN sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      btn_q_r     <= 3'b000;
      pend_alg_r  <= 1'b0;
      pend_pos_r  <= 1'b0;
      alg_done_r  <= 1'b0;
      pos_done_r  <= 1'b0;
      alg_val_r   <= 2'd0;
      pos_val_r   <= {DATA_W{1'b0}};
      last_cpu_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
`ifdef CMD_WDOG_EN
      wdog_cnt_r  <= {CNT_W{1'b0}};
      err_r       <= 1'b0;
`endif
    end else begin
      btn_q_r    <= btn;
      pend_alg_r <= pend_alg_n_s;
      pend_pos_r <= pend_pos_n_s;
      alg_val_r  <= alg_val_n_s;
      alg_done_r <= alg_done_n_s;
      pos_done_r <= pos_done_n_s;
      if (rise_s[2]) begin
        pos_val_r <= DATA_W'(bytePos);
      end
      mem_we_r <= cpu_gnt_s | int_gnt_s;
      if (cpu_gnt_s) begin
        last_cpu_r  <= 1'b1;
        mem_addr_r  <= cpu_addr;
        mem_wdata_r <= cpu_wdata;
      end else if (int_gnt_s) begin
        last_cpu_r  <= 1'b0;
        mem_addr_r  <= {{(ADDR_W-1){1'b0}}, ~pend_alg_r};
        mem_wdata_r <= pend_alg_r ? {{(DATA_W-2){1'b0}}, alg_val_r} : pos_val_r;
      end
      start_r <= 1'b0;
`ifdef CMD_WDOG_EN
      err_r   <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (go_run_s) begin
            state_r <= RUN;
            start_r <= 1'b1;
            busy_r  <= 1'b1;
`ifdef CMD_WDOG_EN
            wdog_cnt_r <= {CNT_W{1'b0}};
`endif
          end
        end
        RUN: begin
          if (done) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            alg_done_r <= 1'b0;
            pos_done_r <= 1'b0;
`ifdef CMD_WDOG_EN
          end else if (wdog_cnt_r == CNT_W'(TIMEOUT - 1)) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            alg_done_r <= 1'b0;
            pos_done_r <= 1'b0;
            err_r      <= 1'b1;
          end else begin
            wdog_cnt_r <= wdog_cnt_r + 1'b1;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_gnt   = cpu_gnt_s;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign start     = start_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: a command-level reference model queues expected RAM writes
// and start/busy/err values; a negedge monitor compares them with what the DUT presents.
module tb_cmd_sequencer;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] btn = 3'b000;
  logic [7:0] bytePos = 8'd0;
  logic cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic cpu_gnt, mem_we, start, done, busy, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always #5 clk = ~clk;

  cmd_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .btn(btn), .bytePos(bytePos), .cpu_req(cpu_req),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .start(start), .done(done),
    .busy(busy), .err(err));

  typedef struct { int cyc; logic [15:0] addr; logic [7:0] data; } wr_t;
  wr_t expq[$];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit chk_en = 1'b0;

  // Reference model: what the block has been asked to do, not how it is built.
  bit m_alg_pend, m_pos_pend, m_alg_written, m_pos_written, m_running, m_cpu_had_last;
  int m_alg, m_pos, m_run_cycles;
  bit [2:0] m_prev_btn;
  bit e_start, e_busy, e_err, n_start, n_busy, n_err;
  bit last_cpu_gnt;
  logic [15:0] c_addr;
  logic [7:0] c_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare registered outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_we;
      while (expq.size() > 0 && expq[0].cyc < cyc) void'(expq.pop_front());
      exp_we = (expq.size() > 0 && expq[0].cyc == cyc);
      check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      if (exp_we && mem_we === 1'b1) begin
        wr_t w;
        w = expq.pop_front();
        check("mem_addr", {16'd0, mem_addr}, {16'd0, w.addr});
        check("mem_wdata", {24'd0, mem_wdata}, {24'd0, w.data});
      end
      check("start", {31'd0, start}, {31'd0, e_start});
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("err", {31'd0, err}, {31'd0, e_err});
    end
  end

  task automatic model_step(input bit r, input bit [2:0] b, input bit [7:0] bp, input bit cr,
                            input bit [15:0] ca, input bit [7:0] cd, input bit dn, output bit gc);
    bit any_int, g_alg, g_pos;
    bit [2:0] rises;
    n_start = 1'b0;
    n_err = 1'b0;
    gc = 1'b0;
    if (r) begin
      m_alg_pend = 0; m_pos_pend = 0; m_alg_written = 0; m_pos_written = 0;
      m_running = 0; m_cpu_had_last = 0; m_prev_btn = 3'b000; n_busy = 0;
      return;
    end
    any_int = m_alg_pend || m_pos_pend;
    gc = cr && (!any_int || !m_cpu_had_last);
    g_alg = !gc && m_alg_pend;
    g_pos = !gc && !m_alg_pend && m_pos_pend;
    if (gc) begin
      expq.push_back('{cyc + 1, ca, cd});
      m_cpu_had_last = 1;
    end else if (g_alg) begin
      expq.push_back('{cyc + 1, 16'd0, 8'(m_alg)});
      m_cpu_had_last = 0;
      m_alg_pend = 0; m_alg_written = 1;
    end else if (g_pos) begin
      expq.push_back('{cyc + 1, 16'd1, 8'(m_pos)});
      m_cpu_had_last = 0;
      m_pos_pend = 0; m_pos_written = 1;
    end
    rises = m_running ? 3'b000 : (b & ~m_prev_btn);
    m_prev_btn = b;
    if (rises[0]) begin m_alg_pend = 1; m_alg = 1; end
    else if (rises[1]) begin m_alg_pend = 1; m_alg = 2; end
    if (rises[2]) begin m_pos_pend = 1; m_pos = bp; end
    if (!m_running) begin
      if (m_alg_written && m_pos_written && !m_alg_pend && !m_pos_pend) begin
        m_running = 1; n_start = 1; m_run_cycles = 0;
      end
    end else if (dn) begin
      m_running = 0; m_alg_written = 0; m_pos_written = 0;
    end else begin
      m_run_cycles++;
`ifdef CMD_WDOG_EN
      if (m_run_cycles == TIMEOUT) begin
        m_running = 0; m_alg_written = 0; m_pos_written = 0; n_err = 1;
      end
`endif
    end
    n_busy = m_running;
  endtask

  // One clock of stimulus: drive inputs after the edge, check the grant, advance the model.
  task automatic st(input bit r, input bit [2:0] b, input bit [7:0] bp, input bit cr, input bit dn);
    bit gc;
    @(posedge clk);
    #1;
    e_start = n_start; e_busy = n_busy; e_err = n_err;
    rst = r; btn = b; bytePos = bp; cpu_req = cr; cpu_addr = c_addr; cpu_wdata = c_data; done = dn;
    #1;
    model_step(r, b, bp, cr, c_addr, c_data, dn, gc);
    if (chk_en) check("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, gc});
    last_cpu_gnt = gc;
  endtask

  task automatic idle(input int n, input bit dn);
    for (int i = 0; i < n; i++) st(0, 3'b000, 8'd0, 0, dn);
  endtask

  task automatic go_run(input bit [7:0] bp);
    st(0, 3'b000, 8'd0, 0, 0);
    st(0, 3'b001, 8'd0, 0, 0);
    st(0, 3'b000, 8'd0, 0, 0);
    st(0, 3'b100, bp, 0, 0);
    idle(4, 0);
  endtask

  initial begin
    bit [2:0] rb;
    bit rcr;
    done = 1'b0;
    c_addr = 16'h0000; c_data = 8'h00;
    st(1, 3'b000, 8'd0, 0, 0);
    st(1, 3'b000, 8'd0, 0, 0);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_gnt", {31'd0, cpu_gnt}, 32'd0);

    // Basic sequence: alg 1 then position 0x2A, run until done.
    go_run(8'h2A);
    idle(5, 0);
    check("busy_held", {31'd0, busy}, 32'd1);
    st(0, 3'b000, 8'd0, 0, 1);
    idle(3, 0);

    // Simultaneous alg buttons, then a later alg-2 press while CPU holds the port.
    st(0, 3'b011, 8'd0, 0, 0);
    idle(3, 0);
    c_addr = 16'h0200; c_data = 8'hA5;
    st(0, 3'b001, 8'd0, 0, 0);
    st(0, 3'b011, 8'd0, 1, 0);
    st(0, 3'b011, 8'd0, 0, 0);
    idle(3, 0);

    // CPU held continuously while both internal writes are pending.
    c_addr = 16'h0100; c_data = 8'h55;
    st(0, 3'b000, 8'd0, 1, 0);
    st(0, 3'b101, 8'h3C, 1, 0);
    for (int i = 0; i < 6; i++) st(0, 3'b101, 8'h3C, 1, 0);
    st(0, 3'b000, 8'd0, 0, 0);
    idle(2, 0);

    // Position press during RUN must be dropped; a second run needs fresh writes.
    st(0, 3'b100, 8'h77, 0, 0);
    st(0, 3'b100, 8'h77, 0, 1);
    idle(6, 0);
    check("no_restart", {31'd0, busy}, 32'd0);
    go_run(8'h11);
    st(0, 3'b000, 8'd0, 0, 1);
    idle(2, 0);

    // Reset mid-RUN with a CPU request, and reset right after a button edge.
    go_run(8'h22);
    c_addr = 16'h0300; c_data = 8'h33;
    st(0, 3'b001, 8'd0, 0, 0);
    st(1, 3'b001, 8'd0, 1, 0);
    st(0, 3'b000, 8'd0, 0, 0);
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_we", {31'd0, mem_we}, 32'd0);
    idle(2, 0);
    st(0, 3'b010, 8'd0, 0, 0);
    st(1, 3'b010, 8'd0, 0, 0);
    idle(4, 0);

    // Watchdog: never assert done.
    go_run(8'h44);
    idle(40, 0);
`ifdef CMD_WDOG_EN
    check("wdog_busy", {31'd0, busy}, 32'd0);
`else
    check("wdog_busy", {31'd0, busy}, 32'd1);
`endif
    st(0, 3'b000, 8'd0, 0, 1);
    idle(2, 0);

    // Randomized traffic; CPU holds address/data until granted.
    rb = 3'b000; rcr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 3; k++) if ($urandom_range(0, 3) == 0) rb[k] = ~rb[k];
      if (!rcr || last_cpu_gnt) begin
        rcr = ($urandom_range(0, 2) == 0);
        c_addr = 16'($urandom);
        c_data = 8'($urandom);
      end
      st(($urandom_range(0, 499) == 0), rb, 8'($urandom), rcr, ($urandom_range(0, 15) == 0));
    end
    idle(4, 1);
    check("queue_drained", expq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
